// File: rtl/seq_decimal_display_pkg.sv
// rtl/seq_decimal_display_pkg.sv - shared constants, state type and helpers for the decimal display driver
package seq_decimal_display_pkg;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_FINISH
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - BCD digit to active-low seven-segment pattern
// Non-decimal codes show a blank display.
module seven_segment (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seq_decimal_display.sv
// rtl/seq_decimal_display.sv - iterative binary-to-decimal seven-segment display driver
// One double-dabble step per clock; display outputs only change on the done edge.
module seq_decimal_display
  import seq_decimal_display_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DIGITS        = 5,
  parameter int SIGNED_MODE   = 1,
  parameter int LEADING_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      val,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [6:0]            seg7_neg_sign,
  output logic [7*DIGITS-1:0]   seg7_digits
);

  localparam int          CW      = $clog2(WIDTH);
  localparam int          BW      = 4 * DIGITS;
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  state_t state, state_next;

  logic [WIDTH-1:0]    val_q;
  logic [WIDTH-1:0]    mag_q;
  logic [WIDTH-1:0]    mag_c;
  logic                neg_c;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       bcd_adj;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic                ovf_q;

  logic                done_q;
  logic                ovf_out_q;
  logic [6:0]          neg_seg_q;
  logic [7*DIGITS-1:0] digits_q;

  logic [7*DIGITS-1:0] dec_seg;
  logic [7*DIGITS-1:0] fin_digits;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_CONV;
      ST_CONV:   if (cnt_q == '0) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CONV) || (state == ST_FINISH);

  // Negating the most negative value still fits as an unsigned WIDTH-bit magnitude.
  assign neg_c = (SIGNED_MODE != 0) && val_q[WIDTH-1];
  assign mag_c = neg_c ? (~val_q + WIDTH'(1)) : val_q;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_nib
      assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? (bcd_q[4*g +: 4] + 4'd3)
                                                            : bcd_q[4*g +: 4];
      seven_segment u_seg (
        .digit (bcd_q[4*g +: 4]),
        .seg   (dec_seg[7*g +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) val_q <= val;
        end
        ST_LOAD: begin
          neg_q <= neg_c;
          mag_q <= mag_c;
          ovf_q <= ({{(64-WIDTH){1'b0}}, mag_c} > MAX_VAL);
          bcd_q <= '0;
          cnt_q <= CW'(WIDTH - 1);
        end
        ST_CONV: begin
          // Bits leaving the top nibble only matter when the result is dashed anyway.
          bcd_q <= {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) zero_run = 1'b0;
      blank[k] = zero_run;
    end
  end

  always_comb begin
    fin_digits = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_q) begin
        fin_digits[7*k +: 7] = SEG_DASH;
      end else if ((LEADING_BLANK != 0) && blank[k]) begin
        fin_digits[7*k +: 7] = SEG_BLANK;
      end else begin
        fin_digits[7*k +: 7] = dec_seg[7*k +: 7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      neg_seg_q <= SEG_BLANK;
      digits_q  <= {DIGITS{SEG_BLANK}};
    end else begin
      done_q <= (state == ST_FINISH);
      if (state == ST_FINISH) begin
        ovf_out_q <= ovf_q;
        neg_seg_q <= neg_q ? SEG_DASH : SEG_BLANK;
        digits_q  <= fin_digits;
      end
    end
  end

  assign done          = done_q;
  assign overflow      = ovf_out_q;
  assign seg7_neg_sign = neg_seg_q;
  assign seg7_digits   = digits_q;

endmodule

// File: tb/tb_seq_decimal_display.sv
// tb/tb_seq_decimal_display.sv - scoreboard bench for seq_decimal_display (signed and unsigned instances)
module tb_seq_decimal_display;

  typedef struct {
    logic [34:0] digits;
    logic [6:0]  neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [31:0] val_a, val_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [6:0]  neg_a, neg_b;
  logic [34:0] dig_a, dig_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  seq_decimal_display #(.WIDTH(32), .DIGITS(5), .SIGNED_MODE(1), .LEADING_BLANK(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .val(val_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .seg7_neg_sign(neg_a), .seg7_digits(dig_a)
  );

  seq_decimal_display #(.WIDTH(32), .DIGITS(5), .SIGNED_MODE(0), .LEADING_BLANK(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .val(val_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .seg7_neg_sign(neg_b), .seg7_digits(dig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 = blank, -2 = dash, 0..9 = digit
  function automatic logic [6:0] dseg(input int d);
    case (d)
      -2: return 7'h3F;
      0:  return 7'h40;
      1:  return 7'h79;
      2:  return 7'h24;
      3:  return 7'h30;
      4:  return 7'h19;
      5:  return 7'h12;
      6:  return 7'h02;
      7:  return 7'h78;
      8:  return 7'h00;
      9:  return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [34:0] build(input int d4, input int d3, input int d2, input int d1, input int d0);
    return {dseg(d4), dseg(d3), dseg(d2), dseg(d1), dseg(d0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit sel, input bit neg, input bit ovf,
                          input int d4, input int d3, input int d2, input int d1, input int d0);
    exp_t e;
    e.digits = build(d4, d3, d2, d1, d0);
    e.neg    = neg ? 7'h3F : 7'h7F;
    e.ovf    = ovf;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Issue one start, wait (bounded) for done, check latency and busy length.
  task automatic run_conv(input bit sel, input logic [31:0] v);
    int cyc;
    int bcnt;
    bit seen;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; val_b = v; end
    else     begin start_a = 1'b1; val_a = v; end
    cyc = 0; bcnt = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0; start_b = 1'b0;
      val_a = 32'hDEADBEEF; val_b = 32'hDEADBEEF;
      if (sel ? busy_b : busy_a) bcnt++;
      if (sel ? done_b : done_a) seen = 1'b1;
    end
    check("done_latency", 64'(cyc - 1), 64'd34);
    check("busy_cycles", 64'(bcnt), 64'd33);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_a: got done=1, expected no done");
        end else begin
          e = q_a.pop_front();
          check("digits_a", 64'(dig_a), 64'(e.digits));
          check("neg_a", 64'(neg_a), 64'(e.neg));
          check("ovf_a", 64'(ovf_a), 64'(e.ovf));
        end
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_b: got done=1, expected no done");
        end else begin
          e = q_b.pop_front();
          check("digits_b", 64'(dig_b), 64'(e.digits));
          check("neg_b", 64'(neg_b), 64'(e.neg));
          check("ovf_b", 64'(ovf_b), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    int  cyc;
    int  dcnt;
    bit  seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; val_a = '0; val_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    check("rst_digits", 64'(dig_a), 64'(build(-1, -1, -1, -1, -1)));
    check("rst_neg", 64'(neg_a), 64'h7F);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_exp(0, 0, 0, -1, -1, -1, -1, 0);  run_conv(0, 32'd0);
    push_exp(0, 0, 0, -1, -1, -1, -1, 7);  run_conv(0, 32'd7);
    push_exp(0, 1, 0, -1, -1, -1, -1, 7);  run_conv(0, 32'hFFFFFFF9);
    push_exp(0, 1, 0, 1, 2, 3, 4, 5);      run_conv(0, 32'hFFFFCFC7);
    push_exp(0, 0, 0, 9, 9, 9, 9, 9);      run_conv(0, 32'd99999);
    push_exp(0, 0, 1, -2, -2, -2, -2, -2); run_conv(0, 32'd100000);
    push_exp(0, 1, 1, -2, -2, -2, -2, -2); run_conv(0, 32'h80000000);
    push_exp(1, 0, 1, -2, -2, -2, -2, -2); run_conv(1, 32'hFFFFFFFF);
    push_exp(1, 0, 0, 1, 2, 3, 4, 5);      run_conv(1, 32'h00003039);

    // start held high while busy, then re-armed in the done cycle
    push_exp(0, 0, 0, -1, -1, -1, 4, 2);
    @(negedge clk);
    start_a = 1'b1; val_a = 32'd42;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b1; val_a = 32'd99999 + 32'(cyc);
      if (done_a) seen = 1'b1;
    end
    check("b2b_first_latency", 64'(cyc - 1), 64'd34);
    val_a = 32'd5;
    push_exp(0, 0, 0, -1, -1, -1, -1, 5);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0; val_a = 32'd777;
      if (cyc == 10) check("hold_old_result", 64'(dig_a), 64'(build(-1, -1, -1, 4, 2)));
      if (done_a) seen = 1'b1;
    end
    check("b2b_second_latency", 64'(cyc - 1), 64'd34);

    // reset in the middle of a conversion; no done may follow
    @(negedge clk);
    start_a = 1'b1; val_a = 32'd12345;
    repeat (10) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_digits", 64'(dig_a), 64'(build(-1, -1, -1, -1, -1)));
    check("abort_neg", 64'(neg_a), 64'h7F);
    check("abort_ovf", 64'(ovf_a), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    repeat (3) @(negedge clk);
    check("queue_a_empty", 64'(q_a.size()), 64'd0);
    check("queue_b_empty", 64'(q_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
